// File: rtl/alu_flag_wb.sv
// Writeback stage behind the 4-bit ALU. It holds results in a 2-entry buffer, derives Z/V/N
// flags for each result, commits them when an entry is popped, and counts committed overflows.
module alu_flag_wb #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ALU_Out,
    input  logic             Error,
    input  logic [1:0]       Opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_flags,
    output logic [2:0]       flag_reg,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky,
    input  logic             clr_err
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b10;

    logic [WIDTH-1:0] data_q [2];
    logic [2:0]       flags_q [2];
    logic [1:0]       op_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [2:0]       flag_reg_q, flag_reg_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_sticky_q, err_sticky_d;

    logic             push, pop;
    logic [2:0]       flags_in;
    logic             arith_in;
    logic [2:0]       head_flags;
    logic             head_arith;
    logic             head_ovf;

    // in_ready depends only on occupancy, so the producer never sees a path from out_ready
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign arith_in  = (Opcode == OP_ADD) || (Opcode == OP_SUB);
    assign flags_in  = {(ALU_Out == '0), arith_in & Error, ALU_Out[WIDTH-1]};

    assign head_flags = flags_q[rd_ptr_q];
    assign head_arith = (op_q[rd_ptr_q] == OP_ADD) || (op_q[rd_ptr_q] == OP_SUB);
    assign head_ovf   = pop & head_arith & head_flags[1];

    assign out_data   = out_valid ? data_q[rd_ptr_q] : '0;
    assign out_flags  = out_valid ? head_flags : 3'b000;
    assign flag_reg   = flag_reg_q;
    assign err_count  = err_count_q;
    assign err_sticky = err_sticky_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Logic ops leave V untouched so a prior arithmetic overflow stays visible
    always_comb begin
        flag_reg_d = flag_reg_q;
        if (pop) begin
            if (head_arith) begin
                flag_reg_d = head_flags;
            end else begin
                flag_reg_d = {head_flags[2], flag_reg_q[1], head_flags[0]};
            end
        end
    end

    always_comb begin
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        if (clr_err) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end else if (head_ovf) begin
            err_sticky_d = 1'b1;
            if (err_count_q != {CNT_W{1'b1}}) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            flags_q[0] <= 3'b000;
            flags_q[1] <= 3'b000;
            op_q[0]    <= 2'b00;
            op_q[1]    <= 2'b00;
        end else if (push) begin
            data_q[wr_ptr_q]  <= ALU_Out;
            flags_q[wr_ptr_q] <= flags_in;
            op_q[wr_ptr_q]    <= Opcode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            flag_reg_q   <= 3'b000;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            flag_reg_q   <= flag_reg_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

endmodule

// File: tb/tb_alu_flag_wb.sv
// Scoreboard bench for alu_flag_wb, built with a 2-bit overflow counter so that saturation can be reached.
module tb_alu_flag_wb;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] ALU_Out;
    logic       Error;
    logic [1:0] Opcode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [2:0] out_flags;
    logic [2:0] flag_reg;
    logic [1:0] err_count;
    logic       err_sticky;
    logic       clr_err;

    alu_flag_wb #(.WIDTH(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALU_Out    (ALU_Out),
        .Error      (Error),
        .Opcode     (Opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_flags  (out_flags),
        .flag_reg   (flag_reg),
        .err_count  (err_count),
        .err_sticky (err_sticky),
        .clr_err    (clr_err)
    );

    typedef struct {
        logic [3:0] data;
        logic [2:0] flags;
        logic [1:0] op;
    } ent_t;

    ent_t       sb[$];
    logic [2:0] m_flag;
    logic [1:0] m_cnt;
    logic       m_sticky;
    logic       did_push, did_pop;
    int         n_tests, n_fail;
    int         pushes, pops;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_arith(input logic [1:0] op);
        return (op == 2'b00) || (op == 2'b10);
    endfunction

    // Inputs are driven just after a rising edge; the handshake is resolved at the falling edge.
    task automatic step();
        ent_t e;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            check("out_data", 32'(out_data), 32'(sb[0].data));
            check("out_flags", 32'(out_flags), 32'(sb[0].flags));
        end
        did_push = in_valid && in_ready;
        did_pop  = out_valid && out_ready;
        if (did_pop && sb.size() > 0) begin
            e = sb.pop_front();
            if (is_arith(e.op)) m_flag = e.flags;
            else                m_flag = {e.flags[2], m_flag[1], e.flags[0]};
            if (is_arith(e.op) && e.flags[1]) begin
                if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
                m_sticky = 1'b1;
            end
        end
        if (clr_err) begin
            m_cnt    = 2'd0;
            m_sticky = 1'b0;
        end
        if (did_push) begin
            e.data  = ALU_Out;
            e.op    = Opcode;
            e.flags = {(ALU_Out == 4'h0), is_arith(Opcode) & Error, ALU_Out[3]};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check("flag_reg", 32'(flag_reg), 32'(m_flag));
        check("err_count", 32'(err_count), 32'(m_cnt));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    endtask

    task automatic send(input logic [3:0] d, input logic [1:0] op, input logic e);
        in_valid = 1'b1;
        ALU_Out  = d;
        Opcode   = op;
        Error    = e;
        for (int i = 0; i < 16; i++) begin
            step();
            if (did_push) break;
        end
        if (!did_push) check("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 8 && sb.size() > 0; i++) step();
        check("drain_empty", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0;
        m_flag = 3'b000; m_cnt = 2'd0; m_sticky = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
        ALU_Out = 4'h0; Error = 1'b0; Opcode = 2'b00;
        #22;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_flags", 32'(out_flags), 32'(0));
        check("rst_flag_reg", 32'(flag_reg), 32'(0));
        check("rst_err_count", 32'(err_count), 32'(0));
        check("rst_err_sticky", 32'(err_sticky), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // zero result through ADD
        out_ready = 1'b1;
        send(4'h0, 2'b00, 1'b0);
        check("t1_out_valid", 32'(out_valid), 32'(1));
        check("t1_out_flags", 32'(out_flags), 32'(3'b100));
        step();
        check("t1_flag_reg", 32'(flag_reg), 32'(3'b100));

        // ADD overflow then XOR keeps V
        send(4'h8, 2'b00, 1'b1);
        send(4'h3, 2'b01, 1'b0);
        check("t2_flag_reg_a", 32'(flag_reg), 32'(3'b011));
        check("t2_err_count", 32'(err_count), 32'(1));
        step();
        check("t2_flag_reg_b", 32'(flag_reg), 32'(3'b010));
        check("t2_err_sticky", 32'(err_sticky), 32'(1));
        drain();

        // back-pressure: fill, producer holds third entry
        out_ready = 1'b0;
        send(4'h1, 2'b00, 1'b0);
        send(4'h2, 2'b01, 1'b0);
        check("t3_in_ready_full", 32'(in_ready), 32'(0));
        in_valid = 1'b1; ALU_Out = 4'h3; Opcode = 2'b11; Error = 1'b0;
        step();
        check("t3_held_a", 32'(did_push), 32'(0));
        step();
        check("t3_held_b", 32'(did_push), 32'(0));
        out_ready = 1'b1;
        send(4'h3, 2'b11, 1'b0);
        drain();

        // streaming at full rate
        pushes = 0; pops = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ALU_Out = 4'($urandom_range(0, 15));
            Opcode  = 2'($urandom_range(0, 3));
            Error   = 1'($urandom_range(0, 1));
            step();
            if (did_push) pushes++;
            if (did_pop) pops++;
            check("t4_occupancy", 32'(sb.size()), 32'(1));
        end
        in_valid = 1'b0;
        check("t4_pushes", 32'(pushes), 32'(20));
        check("t4_pops", 32'(pops), 32'(19));
        drain();

        // counter saturation and clear priority
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t5_cleared", 32'(err_count), 32'(0));
        for (int i = 0; i < 5; i++) send(4'($urandom_range(0, 15)), 2'b10, 1'b1);
        step();
        check("t5_saturated", 32'(err_count), 32'(3));
        check("t5_sticky", 32'(err_sticky), 32'(1));
        send(4'h5, 2'b10, 1'b1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t5_clr_pop", 32'(did_pop), 32'(1));
        check("t5_clr_count", 32'(err_count), 32'(0));
        check("t5_clr_sticky", 32'(err_sticky), 32'(0));
        check("t5_flag_v", 32'(flag_reg[1]), 32'(1));

        // asynchronous reset with two entries buffered
        out_ready = 1'b0;
        send(4'h9, 2'b00, 1'b1);
        send(4'hA, 2'b10, 1'b0);
        check("t6_full", 32'(out_valid & ~in_ready), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'(0));
        check("t6_in_ready", 32'(in_ready), 32'(1));
        check("t6_flag_reg", 32'(flag_reg), 32'(0));
        sb.delete();
        m_flag = 3'b000; m_cnt = 2'd0; m_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'hF, 2'b11, 1'b0);
        drain();
        check("t6_flag_post", 32'(flag_reg), 32'(3'b001));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
